// File: rtl/dot_acc_pkg.sv
// Shared types and Q8.8 constants for the dot-product accumulator.
package dot_acc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } state_e;

  localparam int          FRAC_BITS = 8;
  localparam logic [15:0] Q_MAX     = 16'h7FFF;
  localparam logic [15:0] Q_MIN     = 16'h8000;

  // Smallest accumulator width that cannot wrap when summing len Q8.8 values.
  function automatic int min_acc_w(input int len);
    return 16 + $clog2(len);
  endfunction

endpackage

// File: rtl/dot_acc_q88_sat.sv
// Combinational clamp of a wide signed accumulator into Q8.8 range.
module q88_sat
  import dot_acc_pkg::*;
#(
  parameter int ACC_W = 24
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic        [15:0]      val,
  output logic                    ovf
);

  // Value fits in 16 bits iff every bit from 15 upward equals the sign.
  logic [ACC_W-16:0] hi;
  assign hi = acc[ACC_W-1:15];

  always_comb begin
    val = acc[15:0];
    ovf = !((&hi) || !(|hi));
    if (ovf) val = acc[ACC_W-1] ? Q_MIN : Q_MAX;
  end

endmodule

// File: rtl/dot_acc_16.sv
// Accumulates LEN signed Q8.8 products and emits one saturated Q8.8 result.
module dot_acc_16
  import dot_acc_pkg::*;
#(
  parameter int LEN   = 8,
  parameter int ACC_W = 24
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  input  logic [15:0] prod,
  input  logic        prod_valid,
  output logic        prod_ready,
  output logic [15:0] res,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        busy,
  output logic        ovf
);

  localparam int             CNT_W = $clog2(LEN + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

  state_e                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d, acc_sum;
  logic        [CNT_W-1:0]  cnt_q, cnt_d;
  logic        [15:0]       res_q, res_d, sat_val;
  logic                     ovf_q, ovf_d, sat_ovf;
  logic                     res_valid_q, res_valid_d;
  logic                     xfer;

  assign prod_ready = (state_q == ACC) && !RST;
  assign busy       = (state_q != IDLE) && !RST;
  assign xfer       = prod_valid && prod_ready;
  assign acc_sum    = acc_q + ACC_W'($signed(prod));

  // Clamp is taken on the post-add sum so the result registers on the last transfer.
  q88_sat #(.ACC_W(ACC_W)) u_sat (
    .acc (acc_sum),
    .val (sat_val),
    .ovf (sat_ovf)
  );

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    res_d       = res_q;
    ovf_d       = ovf_q;
    res_valid_d = res_valid_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACC;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      ACC: begin
        if (xfer) begin
          acc_d = acc_sum;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_d     = OUT;
            res_d       = sat_val;
            ovf_d       = sat_ovf;
            res_valid_d = 1'b1;
          end
        end
      end
      OUT: begin
        if (res_ready) begin
          state_d     = IDLE;
          res_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        res_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      res_q       <= '0;
      ovf_q       <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      res_q       <= res_d;
      ovf_q       <= ovf_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign res       = res_q;
  assign ovf       = ovf_q;
  assign res_valid = res_valid_q;

endmodule
